// File: rtl/accel_op_sequencer.sv
// Command-queue sequencer in front of the shared 8-bit ALU: buffers commands, issues them one at a time,
// waits ALU_LAT cycles and holds each result for the consumer. Optional result chaining: ACCEL_SEQ_CHAIN_EN.
module accel_op_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [3:0]  cmd_op,
    input  logic        cmd_chain,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_err,
    output logic        busy
);
    // Both ports use valid/ready: a transfer happens on a rising edge where valid && ready;
    // the producer holds its payload stable until then, and res_data/res_err never change while res_valid is high.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LAT_W = 3;
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
    localparam logic [3:0]       OP_DIV = 4'd3;

    typedef enum logic [1:0] { IDLE, WAIT, HOLD } state_t;
    state_t state, state_nxt;

    logic [7:0]       fifo_a  [DEPTH];
    logic [7:0]       fifo_b  [DEPTH];
    logic [3:0]       fifo_op [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [LAT_W-1:0] cnt;
    logic             push, pop, capture, div_trap;
    logic [7:0]       pop_a;

    assign cmd_ready = (count != FULL);
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (count != '0) || (state != IDLE);
    assign res_valid = (state == HOLD);
    assign div_trap  = (alu_op == OP_DIV) && (alu_b == 8'd0);

`ifdef ACCEL_SEQ_CHAIN_EN
    logic        fifo_chain [DEPTH];
    logic [15:0] last_res;
    logic        unused_last_hi;

    always_ff @(posedge clk) begin
        if (push) fifo_chain[wr_ptr] <= cmd_chain;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       last_res <= '0;
        else if (capture) last_res <= div_trap ? 16'hFFFF : alu_result;
    end

    // Only the low byte feeds back as operand A.
    assign unused_last_hi = ^last_res[15:8];
    assign pop_a          = fifo_chain[rd_ptr] ? last_res[7:0] : fifo_a[rd_ptr];
`else
    logic unused_chain;
    assign unused_chain = cmd_chain;
    assign pop_a        = fifo_a[rd_ptr];
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr]  <= cmd_a;
            fifo_b[wr_ptr]  <= cmd_b;
            fifo_op[wr_ptr] <= cmd_op;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // Handshake and next issue share one edge so back-to-back spacing is ALU_LAT+2.
                if (res_ready) begin
                    if (count != '0) begin
                        pop       = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cnt      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);

            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);

            if (pop) begin
                alu_a  <= pop_a;
                alu_b  <= fifo_b[rd_ptr];
                alu_op <= fifo_op[rd_ptr];
                cnt    <= LAT_W'(ALU_LAT);
                rd_ptr <= rd_ptr + PTR_W'(1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - LAT_W'(1);
            end

            if (capture) begin
                res_data <= div_trap ? 16'hFFFF : alu_result;
                res_err  <= div_trap;
            end
        end
    end

endmodule

// File: tb/tb_accel_op_sequencer.sv
// Bench for accel_op_sequencer: one-cycle ALU model, directed vector table, backpressure,
// reset-during-WAIT and random traffic, all checked against an in-order expected-result queue.
module tb_accel_op_sequencer;
    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 1;
    localparam int NV      = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_chain;
    logic [7:0]  cmd_a, cmd_b;
    logic [3:0]  cmd_op;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_result;
    logic [15:0] alu_q = 16'h0000;
    logic        res_valid, res_ready, res_err, busy;
    logic [15:0] res_data;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_res = 0;
    logic [16:0] exp_q[$];
    logic [15:0] model_last = 16'h0000;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  op;
        logic        chain;
        logic [15:0] data;
        logic        err;
    } vec_t;
    vec_t tbl [NV];

`ifdef ACCEL_SEQ_CHAIN_EN
    localparam logic [15:0] CHAIN_EXP = 16'h0008;
`else
    localparam logic [15:0] CHAIN_EXP = 16'h002F;
`endif

    always #5 clk = ~clk;

    accel_op_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err), .busy(busy)
    );

    // Divide-by-zero returns a junk value so an untrapped capture is visible.
    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        case (op)
            4'd0: return 16'(a) + 16'(b);
            4'd1: return 16'(a) - 16'(b);
            4'd2: return 16'(a) * 16'(b);
            4'd3: return (b == 8'd0) ? 16'h1234 : 16'(a / b);
            4'd4: return {8'h00, a & b};
            4'd5: return {8'h00, a | b};
            4'd6: return {8'h00, a ^ b};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [16:0] exp_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        if (op == 4'd3 && b == 8'd0) return {1'b1, 16'hFFFF};
        return {1'b0, alu_fn(a, b, op)};
    endfunction

    // ALU with one cycle of latency (ALU_LAT = 1).
    always @(posedge clk) alu_q <= alu_fn(alu_a, alu_b, alu_op);
    assign alu_result = alu_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : push_mon
        logic [7:0]  a_eff;
        logic [16:0] e;
        if (rst_n && cmd_valid && cmd_ready) begin
            a_eff = cmd_a;
`ifdef ACCEL_SEQ_CHAIN_EN
            if (cmd_chain) a_eff = model_last[7:0];
`endif
            e = exp_fn(a_eff, cmd_b, cmd_op);
            model_last = e[15:0];
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin : res_mon
        logic [16:0] e;
        if (rst_n && res_valid && res_ready) begin
            n_res++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got 0x%0h err %0b, expected no result", res_data, res_err);
            end else begin
                e = exp_q.pop_front();
                chk("sb_result", {15'b0, res_err, res_data}, {15'b0, e});
            end
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        model_last = 16'h0000;
        rst_n = 1'b1;
    endtask

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input logic ch);
        logic took;
        int   waited;
        took = 1'b0;
        waited = 0;
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        cmd_chain = ch;
        while (!took && waited < 50) begin
            @(negedge clk);
            took = cmd_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        cmd_valid = 1'b0;
        if (!took) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got cmd_ready 0 for %0d cycles, expected accept", waited);
        end
    endtask

    // Returns at a negedge with res_valid high, or records a timeout.
    task automatic wait_res();
        int n;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL result_timeout: got res_valid 0 after %0d cycles, expected 1", n);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic took;
        int   acc;
        int   saved_res;

        tbl[0]  = '{8'h12, 8'h34, 4'd0, 1'b0, 16'h0046, 1'b0};
        tbl[1]  = '{8'hFF, 8'hFF, 4'd2, 1'b0, 16'hFE01, 1'b0};
        tbl[2]  = '{8'h05, 8'h07, 4'd1, 1'b0, 16'hFFFE, 1'b0};
        tbl[3]  = '{8'h40, 8'h00, 4'd3, 1'b0, 16'hFFFF, 1'b1};
        tbl[4]  = '{8'h40, 8'h03, 4'd3, 1'b0, 16'h0015, 1'b0};
        tbl[5]  = '{8'hF0, 8'h3C, 4'd4, 1'b0, 16'h0030, 1'b0};
        tbl[6]  = '{8'hF0, 8'h0F, 4'd5, 1'b0, 16'h00FF, 1'b0};
        tbl[7]  = '{8'hAA, 8'h55, 4'd6, 1'b0, 16'h00FF, 1'b0};
        tbl[8]  = '{8'h77, 8'h11, 4'd9, 1'b0, 16'h0000, 1'b0};
        tbl[9]  = '{8'hFF, 8'hFF, 4'd0, 1'b0, 16'h01FE, 1'b0};
        tbl[10] = '{8'h03, 8'h04, 4'd0, 1'b0, 16'h0007, 1'b0};
        tbl[11] = '{8'h20, 8'h0F, 4'd6, 1'b1, CHAIN_EXP, 1'b0};

        cmd_a = 8'h00;
        cmd_b = 8'h00;
        cmd_op = 4'd0;
        cmd_chain = 1'b0;
        res_ready = 1'b1;
        do_reset();

        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_ops", {12'b0, alu_a, alu_b, alu_op}, 32'd0);

        // Latency: accepted at E0, operands after E1, res_valid after E3, busy low after E4.
        send(8'h12, 8'h34, 4'd0, 1'b0);
        @(posedge clk); #1;
        chk("lat_operands", {12'b0, alu_a, alu_b, alu_op}, {12'b0, 8'h12, 8'h34, 4'd0});
        chk("lat_valid_e1", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_valid_e2", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_valid_e3", 32'(res_valid), 32'd1);
        chk("lat_data_e3", 32'(res_data), 32'h0046);
        chk("lat_busy_e3", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("lat_valid_e4", 32'(res_valid), 32'd0);
        chk("lat_busy_e4", 32'(busy), 32'd0);

        for (int i = 0; i < NV; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].chain);
            wait_res();
            chk($sformatf("vec%0d_data", i), 32'(res_data), 32'(tbl[i].data));
            chk($sformatf("vec%0d_err", i), 32'(res_err), 32'(tbl[i].err));
            @(posedge clk); #1;
        end

        // Backpressure: consumer stalled, DEPTH queued plus one in flight.
        res_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_a = 8'h10; cmd_b = 8'h01; cmd_op = 4'd0; cmd_chain = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            took = cmd_ready;
            @(posedge clk); #1;
            if (took) begin
                acc++;
                cmd_a = 8'(8'h10 + acc);
                cmd_b = 8'(acc);
                cmd_op = 4'(acc % 3);
            end
        end
        cmd_valid = 1'b0;
        chk("bp_accepts", 32'(acc), 32'(DEPTH + 1));
        chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("bp_res_valid", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        for (int k = 0; k < 60 && (exp_q.size() != 0 || busy); k++) begin
            @(posedge clk); #1;
        end
        chk("bp_drained", 32'(exp_q.size()), 32'd0);
        chk("bp_busy_after", 32'(busy), 32'd0);

        // Reset one cycle into WAIT with two commands still queued.
        send(8'h01, 8'h02, 4'd0, 1'b0);
        send(8'h03, 8'h04, 4'd0, 1'b0);
        send(8'h05, 8'h06, 4'd0, 1'b0);
        chk("mid_busy", 32'(busy), 32'd1);
        saved_res = n_res;
        do_reset();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        chk("mid_post_busy", 32'(busy), 32'd0);
        chk("mid_post_alu_ops", {12'b0, alu_a, alu_b, alu_op}, 32'd0);
        chk("mid_post_res_data", 32'(res_data), 32'd0);
        repeat (15) @(posedge clk);
        #1;
        chk("mid_no_result", 32'(n_res), 32'(saved_res));

        // Random traffic with random consumer stalls.
        took = 1'b1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!cmd_valid || took) begin
                cmd_valid = ($urandom_range(0, 3) != 0);
                cmd_a = 8'($urandom_range(0, 255));
                cmd_b = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
                cmd_op = 4'($urandom_range(0, 9));
                cmd_chain = 1'($urandom_range(0, 1));
            end
            res_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            took = cmd_valid && cmd_ready;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < 80 && (exp_q.size() != 0 || busy); k++) begin
            @(posedge clk); #1;
        end
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_busy_after", 32'(busy), 32'd0);
        chk("rand_cmd_ready", 32'(cmd_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
